// File: rtl/addsubmovneg_pipe_pkg.sv
// Shared definitions for the pipelined add/sub/move/negate unit:
// segment-count helpers, configuration legality and the mode-word layout.
package addsubmovneg_pipe_pkg;

  // Bit positions of the per-operation control bits in the mode word
  // that travels down the pipeline alongside the operands.
  localparam int unsigned MODE_SUB = 0;
  localparam int unsigned MODE_ENA = 1;
  localparam int unsigned MODE_SAT = 2;
  localparam int unsigned MODE_W   = 3;

  // Number of carry segments for a given width and segment size.
  function automatic int unsigned nseg_f(input int unsigned w, input int unsigned seg);
    return w / seg;
  endfunction

  // A configuration is legal when W splits into 1..16 whole segments.
  function automatic bit legal_f(input int unsigned w, input int unsigned seg);
    return (seg != 0) && (w % seg == 0) && (w / seg >= 1) && (w / seg <= 16);
  endfunction

endpackage

// File: rtl/addsubmovneg_seg.sv
// Combinational SEG-bit slice: y = (ena ? a : 0) + (sub ? ~b : b) + ci.
// Also reports the carry into the slice MSB, which the top slice uses
// to form the signed overflow flag.
module addsubmovneg_seg
  import addsubmovneg_pipe_pkg::*;
#(
  parameter int unsigned SEG = 4
) (
  input  logic           sub,
  input  logic           ena,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] y,
  output logic           co,
  output logic           cmsb
);

  logic [SEG-1:0] ea_s;
  logic [SEG-1:0] eb_s;
  logic [SEG:0]   sum_s;

  // slice adder; carry into the MSB recovered from the MSB sum bit
  always_comb begin
    ea_s  = ena ? a : {SEG{1'b0}};
    eb_s  = sub ? ~b : b;
    sum_s = {1'b0, ea_s} + {1'b0, eb_s} + {{SEG{1'b0}}, ci};
    y     = sum_s[SEG-1:0];
    co    = sum_s[SEG];
    cmsb  = sum_s[SEG-1] ^ ea_s[SEG-1] ^ eb_s[SEG-1];
  end

endmodule

// File: rtl/addsubmovneg_pipe.sv
// Carry-segmented pipelined add/sub/move/negate unit with optional signed
// saturation and CO/OV/Z flags. Segment k is added in stage k using operands
// held k cycles in skew registers; finished segments are deskewed so the
// full word lines up in the last stage, followed by one flag stage.
module addsubmovneg_pipe
  import addsubmovneg_pipe_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned SEG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         vi,
  input  logic         sub,
  input  logic         ena,
  input  logic         sat,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         vo,
  output logic [W-1:0] y,
  output logic         co,
  output logic         ov,
  output logic         z
);

  localparam int unsigned NSEG = nseg_f(W, SEG);
  localparam int unsigned TOP  = NSEG - 1;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  if (!legal_f(W, SEG)) begin : g_bad_cfg
    $error("addsubmovneg_pipe: W must be a multiple of SEG giving 1..16 segments");
  end

  logic [MODE_W-1:0] mode_in_s;

  // pack the per-operation control bits into the mode word
  always_comb begin
    mode_in_s           = {MODE_W{1'b0}};
    mode_in_s[MODE_SUB] = sub;
    mode_in_s[MODE_ENA] = ena;
    mode_in_s[MODE_SAT] = sat;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = LO + SEG - 1;

    logic              in_valid_s;
    logic [MODE_W-1:0] in_mode_s;
    logic [W-1:LO]     in_a_s;
    logic [W-1:LO]     in_b_s;
    logic              in_c_s;
    logic [SEG-1:0]    seg_y_s;
    logic              seg_co_s;
    logic              seg_cmsb_s;
    logic [HI:0]       res_next_s;

    logic              valid_r;
    logic [MODE_W-1:0] mode_r;
    logic              carry_r;
    logic [HI:0]       res_r;

    if (k == 0) begin : g_head
      assign in_valid_s = vi;
      assign in_mode_s  = mode_in_s;
      assign in_a_s     = a;
      assign in_b_s     = b;
      assign in_c_s     = ci;
      assign res_next_s = seg_y_s;
    end else begin : g_body
      assign in_valid_s = g_stage[k-1].valid_r;
      assign in_mode_s  = g_stage[k-1].mode_r;
      assign in_a_s     = g_stage[k-1].g_skew.opa_r;
      assign in_b_s     = g_stage[k-1].g_skew.opb_r;
      assign in_c_s     = g_stage[k-1].carry_r;
      assign res_next_s = {seg_y_s, g_stage[k-1].res_r};
    end

    addsubmovneg_seg #(.SEG(SEG)) u_seg (
      .sub  (in_mode_s[MODE_SUB]),
      .ena  (in_mode_s[MODE_ENA]),
      .a    (in_a_s[HI:LO]),
      .b    (in_b_s[HI:LO]),
      .ci   (in_c_s),
      .y    (seg_y_s),
      .co   (seg_co_s),
      .cmsb (seg_cmsb_s)
    );

    // stage k: valid, mode, segment carry and the deskewed low result bits
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        mode_r  <= {MODE_W{1'b0}};
        carry_r <= 1'b0;
        res_r   <= {(HI+1){1'b0}};
      end else if (ce) begin
        valid_r <= in_valid_s;
        mode_r  <= in_mode_s;
        carry_r <= seg_co_s;
        res_r   <= res_next_s;
      end
    end

    if (k < TOP) begin : g_skew
      logic [W-1:HI+1] opa_r;
      logic [W-1:HI+1] opb_r;
      // only the top slice's MSB carry feeds the overflow flag
      logic            cmsb_unused_s;
      assign cmsb_unused_s = seg_cmsb_s;

      // skew registers: operand segments not yet added move one stage on
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opa_r <= {(W-HI-1){1'b0}};
          opb_r <= {(W-HI-1){1'b0}};
        end else if (ce) begin
          opa_r <= in_a_s[W-1:HI+1];
          opb_r <= in_b_s[W-1:HI+1];
        end
      end
    end else begin : g_top
      logic              cmsb_r;
      // only SAT is needed past the last adder stage
      logic [MODE_W-1:0] mode_unused_s;
      assign mode_unused_s = mode_r;

      // carry into the word MSB, captured with the final segment
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmsb_r <= 1'b0;
        end else if (ce) begin
          cmsb_r <= seg_cmsb_s;
        end
      end
    end
  end

  logic         last_valid_s;
  logic [W-1:0] raw_s;
  logic [W-1:0] fin_s;
  logic         co_raw_s;
  logic         ov_raw_s;
  logic         sat_s;

  // overflow detection and optional clamp to the signed range
  always_comb begin
    last_valid_s = g_stage[TOP].valid_r;
    raw_s        = g_stage[TOP].res_r;
    co_raw_s     = g_stage[TOP].carry_r;
    ov_raw_s     = co_raw_s ^ g_stage[TOP].g_top.cmsb_r;
    sat_s        = g_stage[TOP].mode_r[MODE_SAT];
    fin_s        = raw_s;
    if (sat_s && ov_raw_s) begin
      if (raw_s[W-1]) begin
        fin_s = SMAX;
      end else begin
        fin_s = SMIN;
      end
    end else begin
      fin_s = raw_s;
    end
  end

  logic         vo_r;
  logic [W-1:0] y_r;
  logic         co_r;
  logic         ov_r;
  logic         z_r;

  // flag stage: result and flags update only for valid ops, hold on bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vo_r <= 1'b0;
      y_r  <= {W{1'b0}};
      co_r <= 1'b0;
      ov_r <= 1'b0;
      z_r  <= 1'b0;
    end else if (ce) begin
      vo_r <= last_valid_s;
      if (last_valid_s) begin
        y_r  <= fin_s;
        co_r <= co_raw_s;
        ov_r <= ov_raw_s;
        z_r  <= (fin_s == {W{1'b0}});
      end
    end
  end

  assign vo = vo_r;
  assign y  = y_r;
  assign co = co_r;
  assign ov = ov_r;
  assign z  = z_r;

endmodule

// File: tb/tb_addsubmovneg_pipe.sv
// Bench for addsubmovneg_pipe: three configurations (16/4, 24/8, 8/8) share
// one stimulus stream; a scoreboard per instance holds expected results and
// the enabled-edge count at which each must appear.
module tb_addsubmovneg_pipe;

  typedef struct {
    logic [23:0] y;
    logic        co;
    logic        ov;
    logic        z;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ce, vi, sub, ena, sat, ci;
  logic [23:0] a, b;

  logic        vo16, co16, ov16, z16;
  logic [15:0] y16;
  logic        vo24, co24, ov24, z24;
  logic [23:0] y24;
  logic        vo8, co8, ov8, z8;
  logic [7:0]  y8;

  exp_t q16[$];
  exp_t q24[$];
  exp_t q8[$];

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  bit en_last = 1'b0;

  logic [19:0] p16;
  logic [27:0] p24;
  logic [11:0] p8;

  addsubmovneg_pipe #(.W(16), .SEG(4)) dut16 (
    .clk(clk), .rst(rst), .ce(ce), .vi(vi), .sub(sub), .ena(ena), .sat(sat),
    .a(a[15:0]), .b(b[15:0]), .ci(ci),
    .vo(vo16), .y(y16), .co(co16), .ov(ov16), .z(z16));

  addsubmovneg_pipe #(.W(24), .SEG(8)) dut24 (
    .clk(clk), .rst(rst), .ce(ce), .vi(vi), .sub(sub), .ena(ena), .sat(sat),
    .a(a), .b(b), .ci(ci),
    .vo(vo24), .y(y24), .co(co24), .ov(ov24), .z(z24));

  addsubmovneg_pipe #(.W(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .ce(ce), .vi(vi), .sub(sub), .ena(ena), .sat(sat),
    .a(a[7:0]), .b(b[7:0]), .ci(ci),
    .vo(vo8), .y(y8), .co(co8), .ov(ov8), .z(z8));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [23:0] yv,
                     input logic cov, input logic ovv, input logic zv);
    chk({tag, "_latency"}, ecnt, e.due);
    chk({tag, "_y"}, {8'd0, yv}, {8'd0, e.y});
    chk({tag, "_co"}, {31'd0, cov}, {31'd0, e.co});
    chk({tag, "_ov"}, {31'd0, ovv}, {31'd0, e.ov});
    chk({tag, "_z"}, {31'd0, zv}, {31'd0, e.z});
  endtask

  // reference: sign-based overflow, independent of carry bookkeeping
  function automatic exp_t model(input int w, input logic [23:0] ta, input logic [23:0] tb,
                                 input logic t_ena, input logic t_sub,
                                 input logic t_sat, input logic t_ci);
    exp_t r;
    logic [31:0] mask, ea, eb, s, smax, smin;
    logic sa, sb, sy, ovf;
    mask = (32'd1 << w) - 32'd1;
    ea   = t_ena ? ({8'd0, ta} & mask) : 32'd0;
    eb   = (t_sub ? ~{8'd0, tb} : {8'd0, tb}) & mask;
    s    = ea + eb + {31'd0, t_ci};
    sa   = ea[w-1];
    sb   = eb[w-1];
    sy   = s[w-1];
    ovf  = (sa == sb) && (sy != sa);
    smax = mask >> 1;
    smin = 32'd1 << (w - 1);
    r.co = s[w];
    r.ov = ovf;
    r.y  = s[23:0] & mask[23:0];
    if (t_sat && ovf) r.y = sy ? smax[23:0] : smin[23:0];
    r.z   = (r.y == 24'd0);
    r.due = 0;
    return r;
  endfunction

  // enabled-edge counter shared by all scoreboards
  always @(posedge clk) begin
    en_last = ce && !rst;
    if (ce && !rst) ecnt++;
  end

  // output monitors: pop on VO after an enabled edge, detect drops, check holds
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (en_last) begin
        if (vo16) begin
          if (q16.size() == 0) chk("d16_spurious_vo", {31'd0, vo16}, 32'd0);
          else begin e = q16.pop_front(); cmp("d16", e, {8'd0, y16}, co16, ov16, z16); end
        end else begin
          if (q16.size() != 0 && q16[0].due <= ecnt) begin
            e = q16.pop_front();
            chk("d16_dropped_vo", {31'd0, vo16}, 32'd1);
          end
          chk("d16_bubble_hold", {13'd0, co16, ov16, z16, y16}, {13'd0, p16[18:0]});
        end
        if (vo24) begin
          if (q24.size() == 0) chk("d24_spurious_vo", {31'd0, vo24}, 32'd0);
          else begin e = q24.pop_front(); cmp("d24", e, y24, co24, ov24, z24); end
        end else begin
          if (q24.size() != 0 && q24[0].due <= ecnt) begin
            e = q24.pop_front();
            chk("d24_dropped_vo", {31'd0, vo24}, 32'd1);
          end
          chk("d24_bubble_hold", {5'd0, co24, ov24, z24, y24}, {5'd0, p24[26:0]});
        end
        if (vo8) begin
          if (q8.size() == 0) chk("d8_spurious_vo", {31'd0, vo8}, 32'd0);
          else begin e = q8.pop_front(); cmp("d8", e, {16'd0, y8}, co8, ov8, z8); end
        end else begin
          if (q8.size() != 0 && q8[0].due <= ecnt) begin
            e = q8.pop_front();
            chk("d8_dropped_vo", {31'd0, vo8}, 32'd1);
          end
          chk("d8_bubble_hold", {21'd0, co8, ov8, z8, y8}, {21'd0, p8[10:0]});
        end
      end else begin
        chk("d16_ce_hold", {12'd0, vo16, co16, ov16, z16, y16}, {12'd0, p16});
        chk("d24_ce_hold", {4'd0, vo24, co24, ov24, z24, y24}, {4'd0, p24});
        chk("d8_ce_hold", {20'd0, vo8, co8, ov8, z8, y8}, {20'd0, p8});
      end
    end
    p16 = {vo16, co16, ov16, z16, y16};
    p24 = {vo24, co24, ov24, z24, y24};
    p8  = {vo8, co8, ov8, z8, y8};
  end

  task automatic step(input logic v, input logic en, input logic [23:0] ta, input logic [23:0] tb,
                      input logic t_ena, input logic t_sub, input logic t_sat, input logic t_ci,
                      input bit has_exp = 1'b0, input logic [15:0] ey = 16'd0,
                      input logic eco = 1'b0, input logic eov = 1'b0, input logic ez = 1'b0);
    exp_t m;
    @(negedge clk);
    #1;
    vi = v; ce = en; a = ta; b = tb; ena = t_ena; sub = t_sub; sat = t_sat; ci = t_ci;
    if (v && en) begin
      m = model(16, ta, tb, t_ena, t_sub, t_sat, t_ci);
      if (has_exp) begin
        m.y = {8'd0, ey}; m.co = eco; m.ov = eov; m.z = ez;
      end
      m.due = ecnt + 5;
      q16.push_back(m);
      m = model(24, ta, tb, t_ena, t_sub, t_sat, t_ci);
      m.due = ecnt + 4;
      q24.push_back(m);
      m = model(8, ta, tb, t_ena, t_sub, t_sat, t_ci);
      m.due = ecnt + 2;
      q8.push_back(m);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 24'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q16.size() + q24.size() + q8.size()) != 0; i++) idle();
    chk("drain_pending", q16.size() + q24.size() + q8.size(), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_d16"}, {12'd0, vo16, co16, ov16, z16, y16}, 32'd0);
    chk({tag, "_d24"}, {4'd0, vo24, co24, ov24, z24, y24}, 32'd0);
    chk({tag, "_d8"}, {20'd0, vo8, co8, ov8, z8, y8}, 32'd0);
  endtask

  initial begin
    int nacc;
    logic v, en, t_ena, t_sub;
    rst = 1'b1; ce = 1'b0; vi = 1'b0; a = 24'd0; b = 24'd0;
    ena = 1'b0; sub = 1'b0; sat = 1'b0; ci = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outputs("reset_state");
    rst = 1'b0;

    // plain add
    step(1'b1, 1'b1, 24'h001234, 24'h001111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 1'b0);
    drain();

    // reset while an op is in flight: it must never appear
    step(1'b1, 1'b1, 24'h000F0F, 24'h000101, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    @(negedge clk);
    #1;
    rst = 1'b1;
    q16.delete(); q24.delete(); q8.delete();
    #1;
    chk_zero_outputs("midflight_reset");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (8) idle();

    // carry ripple, negate with/without saturation, signed overflow cases
    step(1'b1, 1'b1, 24'h00FFFF, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 24'h000000, 24'h008000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000000, 24'h008000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000000, 24'h000005, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'h007000, 24'h002000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h008000, 24'h000001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    drain();

    // mixed add/sub/move stream with VI gaps and CE low for three cycles
    nacc = 0;
    for (int i = 0; i < 13; i++) begin
      v     = !(i == 2 || i == 9);
      en    = !(i >= 5 && i <= 7);
      t_ena = (nacc % 3) != 2;
      t_sub = (nacc % 3) == 1;
      step(v, en, 24'($urandom), 24'($urandom), t_ena, t_sub, 1'($urandom), t_sub);
      if (v && en) nacc++;
    end
    drain();

    // random sweep across all three configurations
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0, 24'($urandom), 24'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
